// File: rtl/des_dout_buf_if.sv
// Result-buffer bus between the DES core/AHB slave side and des_dout_buf.
// The udf status line exists only when DES_DOUT_UDF_EN is defined.
interface des_dout_buf_if #(
    parameter int CNTW = 2
);
    logic            desld;
    logic [63:0]     des_q;
    logic            rd;
    logic [31:0]     rdata;
    logic            dout_rdy;
    logic            dout_full;
    logic [CNTW-1:0] blk_cnt;
    logic            ovf;
`ifdef DES_DOUT_UDF_EN
    logic            udf;
`endif

    modport master (
        output desld,
        output des_q,
        output rd,
        input  rdata,
        input  dout_rdy,
        input  dout_full,
        input  blk_cnt,
`ifdef DES_DOUT_UDF_EN
        input  udf,
`endif
        input  ovf
    );

    modport slave (
        input  desld,
        input  des_q,
        input  rd,
        output rdata,
        output dout_rdy,
        output dout_full,
        output blk_cnt,
`ifdef DES_DOUT_UDF_EN
        output udf,
`endif
        output ovf
    );
endinterface

// File: rtl/des_dout_buf.sv
// DES result buffer: 64-bit blocks in, 32-bit words out (low word first), NBLK deep.
// Optional sticky underflow flag on port udf when DES_DOUT_UDF_EN is defined.
module des_dout_buf #(
    parameter int NBLK = 2,
    parameter int CNTW = 2
) (
    input  logic           hclk,
    input  logic           hresetn,
    input  logic           clrptr,
    des_dout_buf_if.slave  bus
);
    localparam int              PW       = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [PW-1:0]   LAST_PTR = PW'(NBLK - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(NBLK);
    localparam logic [CNTW-1:0] ONE_CNT  = CNTW'(1);

    logic [63:0]     mem_r [NBLK];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic            word_sel_r;
    logic [CNTW-1:0] cnt_r;
    logic            rdy_r;
    logic            full_r;
    logic            ovf_r;

    logic            rd_ok_s;
    logic            pop_s;
    logic            load_ok_s;
    logic            drop_s;
    logic [PW-1:0]   wr_ptr_nxt_s;
    logic [PW-1:0]   rd_ptr_nxt_s;
    logic            word_sel_nxt_s;
    logic [CNTW-1:0] cnt_nxt_s;
    logic            ovf_nxt_s;
    logic [31:0]     rdata_s;

`ifdef DES_DOUT_UDF_EN
    logic            udf_r;
    logic            udf_nxt_s;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] res;
        if (ptr == LAST_PTR) begin
            res = {PW{1'b0}};
        end else begin
            res = ptr + PW'(1);
        end
        return res;
    endfunction

    // Handshake qualification: a pop frees a slot for a same-cycle load.
    always_comb begin
        rd_ok_s   = bus.rd & (cnt_r != {CNTW{1'b0}});
        pop_s     = rd_ok_s & word_sel_r;
        load_ok_s = bus.desld & ((cnt_r != FULL_CNT) | pop_s);
        drop_s    = bus.desld & ~load_ok_s;
    end

    // Next-state for pointers, word select, count and sticky flags.
    always_comb begin
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        word_sel_nxt_s = word_sel_r;
        cnt_nxt_s      = cnt_r;
        ovf_nxt_s      = ovf_r | drop_s;

        if (load_ok_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (rd_ok_s) begin
            word_sel_nxt_s = ~word_sel_r;
        end else begin
            word_sel_nxt_s = word_sel_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({load_ok_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + ONE_CNT;
            2'b01:   cnt_nxt_s = cnt_r - ONE_CNT;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

`ifdef DES_DOUT_UDF_EN
    // Underflow is a read attempt while nothing is held.
    always_comb begin
        if (bus.rd && (cnt_r == {CNTW{1'b0}})) begin
            udf_nxt_s = 1'b1;
        end else begin
            udf_nxt_s = udf_r;
        end
    end
`endif

    // Control state; status flags are registered from the next count.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            word_sel_r <= 1'b0;
            cnt_r      <= {CNTW{1'b0}};
            rdy_r      <= 1'b0;
            full_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (!clrptr) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            word_sel_r <= 1'b0;
            cnt_r      <= {CNTW{1'b0}};
            rdy_r      <= 1'b0;
            full_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            word_sel_r <= word_sel_nxt_s;
            cnt_r      <= cnt_nxt_s;
            rdy_r      <= (cnt_nxt_s != {CNTW{1'b0}});
            full_r     <= (cnt_nxt_s == FULL_CNT);
            ovf_r      <= ovf_nxt_s;
        end
    end

`ifdef DES_DOUT_UDF_EN
    // Sticky underflow register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            udf_r <= 1'b0;
        end else if (!clrptr) begin
            udf_r <= 1'b0;
        end else begin
            udf_r <= udf_nxt_s;
        end
    end
`endif

    // Block storage: no reset, and clrptr leaves contents alone.
    always_ff @(posedge hclk) begin
        if (clrptr && load_ok_s) begin
            mem_r[wr_ptr_r] <= bus.des_q;
        end
    end

    // Head word mux, forced to zero while empty.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (cnt_r != {CNTW{1'b0}}) begin
            if (word_sel_r) begin
                rdata_s = mem_r[rd_ptr_r][63:32];
            end else begin
                rdata_s = mem_r[rd_ptr_r][31:0];
            end
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.rdata     = rdata_s;
    assign bus.dout_rdy  = rdy_r;
    assign bus.dout_full = full_r;
    assign bus.blk_cnt   = cnt_r;
    assign bus.ovf       = ovf_r;
`ifdef DES_DOUT_UDF_EN
    assign bus.udf       = udf_r;
`endif

endmodule

// File: doc/des_dout_buf.md
Name: des_dout_buf

Overview:
- Output-side result buffer for the DES engine, the read-out counterpart of the IV/input register path.
- DES core deposits each 64-bit result block in one cycle. The AHB slave drains it as two 32-bit words, low word first.
- Holds up to NBLK blocks so the core can run ahead of the host.
- Provides ready/full/count status and a sticky overflow flag for the register file.

Parameters:
- NBLK, 2, number of 64-bit result blocks buffered (>=1).
- CNTW, 2, width of block count output; must satisfy 2^CNTW > NBLK.

Ports:
- hclk  input  1  system clock, all logic rising-edge.
- hresetn  input  1  asynchronous active-low reset.
- clrptr  input  1  synchronous active-low clear of pointers, count and flags.
- desld  input  1  core load strobe, one cycle per result block.
- des_q  input  64  result block from DES core, sampled when desld=1.
- rd  input  1  host read strobe, one cycle per 32-bit word consumed.
- rdata  output  32  current head word (combinational from storage).
- dout_rdy  output  1  buffer non-empty.
- dout_full  output  1  buffer holds NBLK blocks.
- blk_cnt  output  CNTW  number of complete or partially read blocks held.
- ovf  output  1  sticky, a load was dropped because buffer was full.

Behaviour:
- Reset (hresetn=0, async): wr_blk=0, rd_blk=0, word_sel=0, blk_cnt=0, ovf=0. Outputs: dout_rdy=0, dout_full=0, rdata=0. Storage is not required to clear.
- clrptr=0 (sync, priority over desld/rd): same pointer/count/flag values as reset. Storage is untouched.
- Storage: NBLK x 64 entries. wr_blk and rd_blk wrap from NBLK-1 to 0.
- Load: desld=1 and (blk_cnt<NBLK or a pop occurs the same cycle) -> mem[wr_blk]<=des_q, wr_blk advances. The block is visible to the reader next cycle; load-to-dout_rdy latency is 1 cycle.
- Load while full with no simultaneous pop: des_q is dropped, pointers are unchanged, and ovf<=1. ovf holds until clrptr=0 or reset.
- Read word order: word_sel=0 selects mem[rd_blk][31:0]; word_sel=1 selects mem[rd_blk][63:32].
- rd=1 with dout_rdy=1:
  - word_sel=0: word_sel<=1.
  - word_sel=1: word_sel<=0, rd_blk advances (pop).
- rd=1 with dout_rdy=0: ignored, no state change.
- rdata=32'b0 whenever dout_rdy=0.
- blk_cnt: +1 on accepted load without pop, -1 on pop without load, unchanged on simultaneous load and pop.
- A partially read block (word_sel=1) still counts as held. A load into a full buffer coincident with the final word read is accepted.
- Flags are derived from blk_cnt: dout_rdy = blk_cnt!=0; dout_full = blk_cnt==NBLK.
- Reset or clrptr mid-read discards the remaining half block; word_sel returns to 0.

Optional Feature:
- Macro DES_DOUT_UDF_EN.
- Defined:
  - Adds output port udf (1 bit), sticky.
  - udf is set on rd=1 while dout_rdy=0; cleared by clrptr=0 or reset.
  - Reset value 0.
- Undefined: port udf is absent; rd while empty is silently ignored.

Test Plan:
- Reset, then desld with des_q=64'h0123456789ABCDEF. Next cycle dout_rdy=1, blk_cnt=1, rdata=32'h89ABCDEF. After rd, rdata=32'h01234567. After second rd, dout_rdy=0, rdata=0.
- Load 64'hA, 64'hB (NBLK=2). Expect dout_full=1, blk_cnt=2. Third desld of 64'hC: ovf=1, blk_cnt=2. Four reads return 0000000A,00000000,0000000B,00000000.
- Full buffer with word_sel=1, then desld 64'hC in the same cycle as the final rd. Expect blk_cnt stays 2 and ovf=0. Later reads return 64'hB then 64'hC words.
- After one word is read from a block, pulse clrptr=0. Expect blk_cnt=0, dout_rdy=0, ovf=0. A new load then reads from its low word.
- Assert hresetn=0 asynchronously mid-cycle with 2 blocks held. Outputs drop to reset values immediately, without waiting for a clock edge.
- DES_DOUT_UDF_EN defined: rd with empty buffer sets udf=1 and leaves state unchanged; clrptr=0 clears it. Macro undefined: same stimulus gives no state change.
